// File: rtl/soc_int_dispatcher.sv
// Interrupt dispatcher: picks one pending source (round-robin or fixed priority),
// presents it with an irq/ack handshake, pulses its clear on ack and waits for irq_done.
module soc_int_dispatcher #(
    parameter int unsigned ROUND_ROBIN = 1,
    parameter int unsigned ACK_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        res,
    input  logic [31:0] pending,
    input  logic        core_halt,
    input  logic        irq_ack,
    input  logic        irq_done,
    output logic        irq,
    output logic [4:0]  irq_id,
    output logic [31:0] int_clears,
    output logic        busy
);

    localparam int unsigned CW = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = (ACK_TIMEOUT > 0) ? CW'(ACK_TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {IDLE, REQUEST, SERVICE} state_t;

    state_t        state_q, state_d;
    logic          irq_q, irq_d;
    logic [4:0]    irq_id_q, irq_id_d;
    logic [4:0]    ptr_q, ptr_d;
    logic [31:0]   int_clears_q, int_clears_d;
    logic          busy_q, busy_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [4:0]    start;
    logic [4:0]    idx;
    logic [4:0]    winner;
    logic          found;

    // 5-bit index arithmetic gives the 31 -> 0 wrap for free
    always_comb begin
        start  = (ROUND_ROBIN != 0) ? ptr_q : '0;
        idx    = '0;
        winner = '0;
        found  = 1'b0;
        for (int unsigned i = 0; i < 32; i++) begin
            idx = start + 5'(i);
            if (!found && pending[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        irq_d        = irq_q;
        irq_id_d     = irq_id_q;
        ptr_d        = ptr_q;
        int_clears_d = '0;
        busy_d       = busy_q;
        cnt_d        = cnt_q;
        case (state_q)
            IDLE: begin
                if (pending != '0 && !core_halt) begin
                    irq_id_d = winner;
                    irq_d    = 1'b1;
                    cnt_d    = '0;
                    state_d  = REQUEST;
                end
            end
            REQUEST: begin
                if (irq_ack) begin
                    int_clears_d = 32'd1 << irq_id_q;
                    irq_d        = 1'b0;
                    busy_d       = 1'b1;
                    state_d      = SERVICE;
                end else if (!pending[irq_id_q]) begin
                    irq_d   = 1'b0;
                    state_d = IDLE;
                end else if (ACK_TIMEOUT != 0 && cnt_q == CNT_LAST) begin
                    // step past the ignored source so the others get a turn
                    irq_d   = 1'b0;
                    ptr_d   = irq_id_q + 5'd1;
                    state_d = IDLE;
                end else if (!core_halt) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SERVICE: begin
                if (irq_done) begin
                    busy_d  = 1'b0;
                    ptr_d   = (ROUND_ROBIN != 0) ? irq_id_q + 5'd1 : '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q      <= IDLE;
            irq_q        <= 1'b0;
            irq_id_q     <= '0;
            ptr_q        <= '0;
            int_clears_q <= '0;
            busy_q       <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            irq_q        <= irq_d;
            irq_id_q     <= irq_id_d;
            ptr_q        <= ptr_d;
            int_clears_q <= int_clears_d;
            busy_q       <= busy_d;
            cnt_q        <= cnt_d;
        end
    end

    assign irq        = irq_q;
    assign irq_id     = irq_id_q;
    assign int_clears = int_clears_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_soc_int_dispatcher.sv
// Bench for soc_int_dispatcher: a round-robin/timeout instance and a fixed-priority/no-timeout
// instance share random stimulus and are compared every cycle against a behavioural model.
module tb_soc_int_dispatcher;

    logic        clk = 1'b0;
    logic        res = 1'b1;
    logic [31:0] pending = '0;
    logic        core_halt = 1'b0;
    logic        irq_ack = 1'b0;
    logic        irq_done = 1'b0;

    logic        rr_irq, fp_irq, rr_busy, fp_busy;
    logic [4:0]  rr_id, fp_id;
    logic [31:0] rr_clr, fp_clr;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    soc_int_dispatcher #(.ROUND_ROBIN(1), .ACK_TIMEOUT(4)) dut_rr (
        .clk(clk), .res(res), .pending(pending), .core_halt(core_halt),
        .irq_ack(irq_ack), .irq_done(irq_done),
        .irq(rr_irq), .irq_id(rr_id), .int_clears(rr_clr), .busy(rr_busy)
    );

    soc_int_dispatcher #(.ROUND_ROBIN(0), .ACK_TIMEOUT(0)) dut_fp (
        .clk(clk), .res(res), .pending(pending), .core_halt(core_halt),
        .irq_ack(irq_ack), .irq_done(irq_done),
        .irq(fp_irq), .irq_id(fp_id), .int_clears(fp_clr), .busy(fp_busy)
    );

    // Model: index 0 mirrors dut_rr, index 1 mirrors dut_fp.
    int unsigned m_rr  [2] = '{1, 0};
    int unsigned m_tmo [2] = '{4, 0};
    bit          m_req [2] = '{0, 0};
    bit          m_svc [2] = '{0, 0};
    int unsigned m_id  [2] = '{0, 0};
    int unsigned m_ptr [2] = '{0, 0};
    int unsigned m_wait[2] = '{0, 0};   // cycles irq has been presented so far
    logic [31:0] m_clr [2] = '{32'h0, 32'h0};

    function automatic int unsigned pick(input int unsigned first, input logic [31:0] p);
        for (int unsigned i = 0; i < 32; i++)
            if (p[(first + i) % 32]) return (first + i) % 32;
        return 0;
    endfunction

    always @(posedge clk or posedge res) begin
        for (int m = 0; m < 2; m++) begin
            if (res) begin
                m_req[m] <= 0; m_svc[m] <= 0; m_id[m] <= 0;
                m_ptr[m] <= 0; m_wait[m] <= 0; m_clr[m] <= '0;
            end else begin
                m_clr[m] <= '0;
                if (m_svc[m]) begin
                    if (irq_done) begin
                        m_svc[m] <= 0;
                        m_ptr[m] <= (m_rr[m] != 0) ? (m_id[m] + 1) % 32 : 0;
                    end
                end else if (m_req[m]) begin
                    if (irq_ack) begin
                        m_clr[m] <= 32'h1 << m_id[m];
                        m_req[m] <= 0;
                        m_svc[m] <= 1;
                    end else if (!pending[m_id[m]]) begin
                        m_req[m] <= 0;
                    end else if (m_tmo[m] != 0 && m_wait[m] == m_tmo[m]) begin
                        m_req[m] <= 0;
                        m_ptr[m] <= (m_id[m] + 1) % 32;
                    end else if (!core_halt) begin
                        m_wait[m] <= m_wait[m] + 1;
                    end
                end else if (pending != 0 && !core_halt) begin
                    m_id[m]   <= pick((m_rr[m] != 0) ? m_ptr[m] : 0, pending);
                    m_req[m]  <= 1;
                    m_wait[m] <= 1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        check("rr.irq",        rr_irq,  m_req[0]);
        check("rr.busy",       rr_busy, m_svc[0]);
        check("rr.irq_id",     rr_id,   m_id[0]);
        check("rr.int_clears", rr_clr,  m_clr[0]);
        check("fp.irq",        fp_irq,  m_req[1]);
        check("fp.busy",       fp_busy, m_svc[1]);
        check("fp.irq_id",     fp_id,   m_id[1]);
        check("fp.int_clears", fp_clr,  m_clr[1]);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        res = 1'b1; pending = '0; core_halt = 1'b0; irq_ack = 1'b0; irq_done = 1'b0;
        cyc();
        res = 1'b0;
    endtask

    initial begin
        cyc(); cyc();
        check("reset.irq",  rr_irq,  0);
        check("reset.id",   rr_id,   0);
        check("reset.clr",  rr_clr,  0);
        check("reset.busy", fp_busy, 0);
        res = 1'b0;

        // fixed priority: lowest index first, one-cycle clear, next is id 4
        do_reset();
        pending = 32'h14; cyc();
        check("fp.first_irq", fp_irq, 1);
        check("fp.first_id",  fp_id,  2);
        cyc(); cyc();
        irq_ack = 1'b1; cyc(); irq_ack = 1'b0;
        check("fp.clear_pulse", fp_clr,  32'h4);
        check("fp.irq_on_ack",  fp_irq,  0);
        check("fp.busy_on_ack", fp_busy, 1);
        pending = 32'h10; cyc();
        check("fp.clear_gone", fp_clr,  0);
        check("fp.busy_held",  fp_busy, 1);
        irq_done = 1'b1; cyc(); irq_done = 1'b0;
        check("fp.busy_done", fp_busy, 0);
        check("fp.idle_gap",  fp_irq,  0);
        cyc();
        check("fp.next_irq", fp_irq, 1);
        check("fp.next_id",  fp_id,  4);

        // round robin alternates between the two held sources
        do_reset();
        pending = 32'h8000_0001; cyc();
        for (int k = 0; k < 4; k++) begin
            check("rr.alt_irq", rr_irq, 1);
            check("rr.alt_id",  rr_id,  (k % 2 == 0) ? 0 : 31);
            check("fp.alt_id",  fp_id,  0);
            irq_ack = 1'b1; cyc(); irq_ack = 1'b0;
            check("rr.alt_clr", rr_clr, (k % 2 == 0) ? 32'h1 : 32'h8000_0000);
            irq_done = 1'b1; cyc(); irq_done = 1'b0;
            check("rr.alt_busy", rr_busy, 0);
            cyc();
        end

        // timeout: 4 cycles high on id 0, one low, then id 1
        do_reset();
        pending = 32'h3; cyc();
        for (int k = 0; k < 4; k++) begin
            check("rr.tmo_high", rr_irq, 1);
            check("rr.tmo_id0",  rr_id,  0);
            cyc();
        end
        check("rr.tmo_low",  rr_irq, 0);
        check("fp.no_tmo",   fp_irq, 1);
        cyc();
        check("rr.tmo_again", rr_irq, 1);
        check("rr.tmo_id1",   rr_id,  1);

        // withdrawal: no clear, back to idle
        do_reset();
        pending = 32'h100; cyc();
        check("rr.wd_id", rr_id, 8);
        pending = '0; cyc();
        check("rr.wd_irq",  rr_irq, 0);
        check("rr.wd_clr",  rr_clr, 0);
        cyc();
        check("rr.wd_idle", rr_irq, 0);
        check("rr.wd_busy", rr_busy, 0);

        // halt freezes dispatch
        do_reset();
        core_halt = 1'b1; pending = 32'h1; cyc(); cyc();
        check("rr.halt_irq", rr_irq, 0);
        core_halt = 1'b0; cyc();
        check("rr.unhalt_irq", rr_irq, 1);
        check("rr.unhalt_id",  rr_id,  0);

        // async reset during service
        do_reset();
        pending = 32'h20; cyc();
        check("rr.ar_id", rr_id, 5);
        irq_ack = 1'b1; cyc(); irq_ack = 1'b0;
        check("rr.ar_busy", rr_busy, 1);
        #2 res = 1'b1;
        #1;
        check("rr.ar_busy0", rr_busy, 0);
        check("rr.ar_irq0",  rr_irq,  0);
        check("rr.ar_id0",   rr_id,   0);
        check("rr.ar_clr0",  rr_clr,  0);
        cyc(); res = 1'b0;
        cyc();
        check("rr.ar_redispatch", rr_irq, 1);
        check("rr.ar_id5",        rr_id,  5);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) == 0) pending = $urandom & $urandom & $urandom;
            else if ($urandom_range(0, 31) == 0) pending = '0;
            irq_ack   = ($urandom_range(0, 3) == 0);
            irq_done  = ($urandom_range(0, 3) == 0);
            core_halt = ($urandom_range(0, 9) == 0);
            res       = ($urandom_range(0, 499) == 0);
            cyc();
        end
        res = 1'b0; irq_ack = 1'b0; irq_done = 1'b0;
        cyc(); cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
